// File: rtl/wptr_full_prog.sv
// Write-side pointer/flag generator for the async FIFO: binary and Gray write
// pointers, fill level, full / almost-full flags, sticky overflow and drop counter.
module wptr_full_prog #(
  parameter int ASIZE = 4,
  parameter int CNTW  = 8
) (
  input  logic             wclk,
  input  logic             wrst_n,
  input  logic             winc,
  input  logic [ASIZE:0]   wq2_rptr,
  input  logic [ASIZE:0]   afull_thresh,
  input  logic             wclr_ovf,
  output logic             wen,
  output logic [ASIZE-1:0] waddr,
  output logic [ASIZE:0]   wptr,
  output logic             wfull,
  output logic             walmost_full,
  output logic [ASIZE:0]   wcount,
  output logic             wovf,
  output logic [CNTW-1:0]  wdrop_cnt
);

  localparam int              DEPTH   = 2 ** ASIZE;
  localparam logic [ASIZE:0]  DEPTH_V = (ASIZE + 1)'(DEPTH);
  localparam logic [CNTW-1:0] CNT_ONE = CNTW'(1);
  localparam logic [CNTW-1:0] CNT_MAX = {CNTW{1'b1}};

  function automatic logic [ASIZE:0] bin2gray(input logic [ASIZE:0] b);
    return (b >> 1) ^ b;
  endfunction

  function automatic logic [ASIZE:0] gray2bin(input logic [ASIZE:0] g);
    logic [ASIZE:0] b;
    b[ASIZE] = g[ASIZE];
    for (int i = ASIZE - 1; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  logic [ASIZE:0]  wbin_r;
  logic            accept_s;
  logic            drop_s;
  logic [ASIZE:0]  wbin_next_s;
  logic [ASIZE:0]  wgray_next_s;
  logic [ASIZE:0]  rbin_s;
  logic [ASIZE:0]  wcount_next_s;
  logic            ovf_next_s;
  logic [CNTW-1:0] drop_next_s;

  // Next pointer values and the fill level they imply against the synchronised read pointer
  always_comb begin
    accept_s      = winc & ~wfull;
    drop_s        = winc & wfull;
    wbin_next_s   = wbin_r + (ASIZE + 1)'(accept_s);
    wgray_next_s  = bin2gray(wbin_next_s);
    rbin_s        = gray2bin(wq2_rptr);
    wcount_next_s = wbin_next_s - rbin_s;
  end

  // Overflow bookkeeping; a drop in the same cycle as a clear restarts the count at one
  always_comb begin
    ovf_next_s  = wovf;
    drop_next_s = wdrop_cnt;
    if (drop_s) begin
      ovf_next_s = 1'b1;
      if (wclr_ovf) begin
        drop_next_s = CNT_ONE;
      end else if (wdrop_cnt == CNT_MAX) begin
        drop_next_s = wdrop_cnt;
      end else begin
        drop_next_s = wdrop_cnt + CNT_ONE;
      end
    end else if (wclr_ovf) begin
      ovf_next_s  = 1'b0;
      drop_next_s = {CNTW{1'b0}};
    end else begin
      ovf_next_s  = wovf;
      drop_next_s = wdrop_cnt;
    end
  end

  assign wen   = accept_s;
  assign waddr = wbin_r[ASIZE-1:0];

  // State registers; full uses the count form, identical to the Gray MSB-inverted compare
  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      wbin_r       <= {(ASIZE + 1){1'b0}};
      wptr         <= {(ASIZE + 1){1'b0}};
      wfull        <= 1'b0;
      walmost_full <= 1'b0;
      wcount       <= {(ASIZE + 1){1'b0}};
      wovf         <= 1'b0;
      wdrop_cnt    <= {CNTW{1'b0}};
    end else begin
      wbin_r       <= wbin_next_s;
      wptr         <= wgray_next_s;
      wfull        <= (wcount_next_s == DEPTH_V);
      walmost_full <= (wcount_next_s >= afull_thresh);
      wcount       <= wcount_next_s;
      wovf         <= ovf_next_s;
      wdrop_cnt    <= drop_next_s;
    end
  end

endmodule
